// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux4
//  Purpose  : Receive-side 1:4 time-division demultiplexer. Locks onto a
//             4-slot frame marked by `sync` on slot 0, collects slots in
//             shadow registers and publishes all four channels atomically
//             once per complete frame.
//  Ports    : clk, rst_n        - clock / async active-low reset
//             en, sync, d       - slot strobe, slot-0 marker, slot data
//             err_clr           - synchronous clear of sync_err
//             o0..o3            - registered channel outputs
//             s                 - next expected slot index (upstream s1,s0)
//             frame_valid       - one-cycle pulse with new o0..o3
//             locked, sync_err  - lock status, sticky framing error
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic [WIDTH-1:0] d,
    input  logic             err_clr,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [1:0]       s,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_d;
    logic [WIDTH-1:0] sh0_q, sh1_q, sh2_q;
    logic [WIDTH-1:0] o0_q, o1_q, o2_q, o3_q;
    logic             fv_q;
    logic             locked_q;
    logic             err_q;

    // Slot counter wraps naturally from 3 back to 0 at frame end.
    assign cnt_d = cnt_q + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_HUNT;
            cnt_q    <= 2'd0;
            sh0_q    <= '0;
            sh1_q    <= '0;
            sh2_q    <= '0;
            o0_q     <= '0;
            o1_q     <= '0;
            o2_q     <= '0;
            o3_q     <= '0;
            fv_q     <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fv_q <= 1'b0;
            // Clear first so that a framing error on the same edge overrides it.
            if (err_clr) begin
                err_q <= 1'b0;
            end
            if (en) begin
                case (state_q)
                    ST_HUNT: begin
                        if (sync) begin
                            sh0_q    <= d;
                            cnt_q    <= 2'd1;
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (sync && (cnt_q != 2'd0)) begin
                            // Early sync: drop the partial frame, restart at slot 0.
                            err_q <= 1'b1;
                            sh0_q <= d;
                            cnt_q <= 2'd1;
                        end else if (!sync && (cnt_q == 2'd0)) begin
                            // Missing sync: frame alignment lost, go hunting.
                            err_q    <= 1'b1;
                            cnt_q    <= 2'd0;
                            state_q  <= ST_HUNT;
                            locked_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_d;
                            case (cnt_q)
                                2'd0: sh0_q <= d;
                                2'd1: sh1_q <= d;
                                2'd2: sh2_q <= d;
                                default: begin
                                    // Last slot bypasses the shadows so all four
                                    // channels change on one edge.
                                    o0_q <= sh0_q;
                                    o1_q <= sh1_q;
                                    o2_q <= sh2_q;
                                    o3_q <= d;
                                    fv_q <= 1'b1;
                                end
                            endcase
                        end
                    end
                    default: begin
                        state_q  <= ST_HUNT;
                        cnt_q    <= 2'd0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o0          = o0_q;
    assign o1          = o1_q;
    assign o2          = o2_q;
    assign o3          = o3_q;
    assign s           = cnt_q;
    assign frame_valid = fv_q;
    assign locked      = locked_q;
    assign sync_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux4
//  Purpose  : Self-checking bench for tdm_demux4 (WIDTH=4). Directed
//             scenarios plus a randomized run against a queue-based
//             frame-collection model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         sync = 1'b0;
    logic [W-1:0] d = '0;
    logic         err_clr = 1'b0;
    logic [W-1:0] o0, o1, o2, o3;
    logic [1:0]   s;
    logic         frame_valid, locked, sync_err;

    int n_cmp = 0;
    int n_fail = 0;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .d(d),
        .err_clr(err_clr), .o0(o0), .o1(o1), .o2(o2), .o3(o3), .s(s),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: frame assembly with a queue ----------
    bit           m_locked;
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_o[4];
    bit           m_fv, m_err;

    task automatic model_reset();
        m_locked = 0; m_q.delete(); m_fv = 0; m_err = 0;
        for (int i = 0; i < 4; i++) m_o[i] = '0;
    endtask

    task automatic model_step(input bit e, input bit sy, input logic [W-1:0] dd, input bit c);
        bit err;
        err  = 0;
        m_fv = 0;
        if (e) begin
            if (!m_locked) begin
                if (sy) begin m_q.delete(); m_q.push_back(dd); m_locked = 1; end
            end else if (sy) begin
                if (m_q.size() != 0) err = 1;
                m_q.delete(); m_q.push_back(dd);
            end else if (m_q.size() == 0) begin
                err = 1; m_locked = 0;
            end else begin
                m_q.push_back(dd);
            end
            if (m_q.size() == 4) begin
                for (int i = 0; i < 4; i++) m_o[i] = m_q[i];
                m_q.delete();
                m_fv = 1;
            end
        end
        if (c)   m_err = 0;
        if (err) m_err = 1;
    endtask

    // One clock: drive at negedge, sample 1 time unit after posedge.
    task automatic drive(input bit e, input bit sy, input logic [W-1:0] dd, input bit c);
        @(negedge clk);
        en = e; sync = sy; d = dd; err_clr = c;
        @(posedge clk);
        model_step(e, sy, dd, c);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        en = 0; sync = 0; err_clr = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if ({o0, o1, o2, o3} !== 16'h0) begin n_fail++; $display("FAIL reset_o: got %h want 0000", {o0, o1, o2, o3}); end
        n_cmp++;
        if ({s, frame_valid, locked, sync_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl: got s=%0d fv=%b lk=%b err=%b want all 0", s, frame_valid, locked, sync_err);
        end
    endtask

    task automatic test_basic_frame();
        logic [W-1:0] dv[4];
        logic [1:0]   es[4];
        dv = '{4'hA, 4'hB, 4'hC, 4'hD};
        es = '{2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, dv[i], 1'b0);
            n_cmp++;
            if (s !== es[i]) begin n_fail++; $display("FAIL basic_s[%0d]: got %0d want %0d", i, s, es[i]); end
            n_cmp++;
            if (locked !== 1'b1) begin n_fail++; $display("FAIL basic_locked[%0d]: got %b want 1", i, locked); end
            n_cmp++;
            if (frame_valid !== (i == 3)) begin n_fail++; $display("FAIL basic_fv[%0d]: got %b want %b", i, frame_valid, i == 3); end
        end
        n_cmp++;
        if ({o0, o1, o2, o3} !== 16'hABCD) begin n_fail++; $display("FAIL basic_o: got %h want abcd", {o0, o1, o2, o3}); end
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        n_cmp++;
        if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL basic_fv_pulse: got %b want 0", frame_valid); end
    endtask

    task automatic test_bubbles();
        logic [W-1:0] dv[4];
        logic [1:0]   es[4];
        dv = '{4'h3, 4'h5, 4'h9, 4'hE};
        es = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, dv[i], 1'b0);
            n_cmp++;
            if (frame_valid !== (i == 3)) begin n_fail++; $display("FAIL bub_fv[%0d]: got %b want %b", i, frame_valid, i == 3); end
            for (int b = 0; b < 2; b++) begin
                drive(1'b0, 1'b1, 4'hF, 1'b0);
                n_cmp++;
                if (s !== es[i] || frame_valid !== 1'b0) begin
                    n_fail++; $display("FAIL bub_hold[%0d]: got s=%0d fv=%b want s=%0d fv=0", i, s, frame_valid, es[i]);
                end
            end
        end
        n_cmp++;
        if ({o0, o1, o2, o3} !== 16'h359E) begin n_fail++; $display("FAIL bub_o: got %h want 359e", {o0, o1, o2, o3}); end
    endtask

    task automatic test_early_sync();
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, W'(i + 1), 1'b0);
        drive(1'b1, 1'b1, 4'h5, 1'b0);
        drive(1'b1, 1'b0, 4'h5, 1'b0);
        drive(1'b1, 1'b1, 4'h6, 1'b0);   // sync while expecting slot 2
        n_cmp++;
        if (sync_err !== 1'b1 || frame_valid !== 1'b0 || s !== 2'd1 || locked !== 1'b1) begin
            n_fail++; $display("FAIL early_flags: got err=%b fv=%b s=%0d lk=%b want 1 0 1 1", sync_err, frame_valid, s, locked);
        end
        n_cmp++;
        if ({o0, o1, o2, o3} !== 16'h1234) begin n_fail++; $display("FAIL early_o_hold: got %h want 1234", {o0, o1, o2, o3}); end
        drive(1'b1, 1'b0, 4'h7, 1'b0);
        drive(1'b1, 1'b0, 4'h8, 1'b0);
        drive(1'b1, 1'b0, 4'h9, 1'b0);
        n_cmp++;
        if ({o0, o1, o2, o3} !== 16'h6789 || frame_valid !== 1'b1) begin
            n_fail++; $display("FAIL early_resync: got %h fv=%b want 6789 fv=1", {o0, o1, o2, o3}, frame_valid);
        end
    endtask

    task automatic test_missing_sync();
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, W'(4'hC - i), 1'b0);
        drive(1'b1, 1'b0, 4'h1, 1'b0);   // no sync at slot 0
        n_cmp++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || s !== 2'd0 || frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL miss_flags: got err=%b lk=%b s=%0d fv=%b want 1 0 0 0", sync_err, locked, s, frame_valid);
        end
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, W'($urandom), 1'b0);
        n_cmp++;
        if (locked !== 1'b0 || s !== 2'd0 || {o0, o1, o2, o3} !== 16'hCBA9) begin
            n_fail++; $display("FAIL miss_hunt: got lk=%b s=%0d o=%h want 0 0 cba9", locked, s, {o0, o1, o2, o3});
        end
        drive(1'b1, 1'b1, 4'h2, 1'b0);
        n_cmp++;
        if (locked !== 1'b1 || s !== 2'd1) begin n_fail++; $display("FAIL miss_relock: got lk=%b s=%0d want 1 1", locked, s); end
    endtask

    task automatic test_err_clr();
        drive(1'b0, 1'b0, 4'h0, 1'b1);   // clear with en=0
        n_cmp++;
        if (sync_err !== 1'b0) begin n_fail++; $display("FAIL clr_alone: got %b want 0", sync_err); end
        drive(1'b1, 1'b1, 4'h4, 1'b1);   // early sync (cnt=1) with clear
        n_cmp++;
        if (sync_err !== 1'b1) begin n_fail++; $display("FAIL clr_vs_err: got %b want 1", sync_err); end
        drive(1'b1, 1'b0, 4'h4, 1'b1);   // normal slot with clear
        n_cmp++;
        if (sync_err !== 1'b0) begin n_fail++; $display("FAIL clr_normal: got %b want 0", sync_err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 4'h8 + W'(i), 1'b0);
        drive(1'b1, 1'b1, 4'h1, 1'b0);
        drive(1'b1, 1'b0, 4'h2, 1'b0);
        n_cmp++;
        if (s !== 2'd2 || {o0, o1, o2, o3} !== 16'h89AB) begin
            n_fail++; $display("FAIL arst_pre: got s=%0d o=%h want 2 89ab", s, {o0, o1, o2, o3});
        end
        @(negedge clk);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o0, o1, o2, o3, s, locked, frame_valid, sync_err} !== 21'h0) begin
            n_fail++; $display("FAIL arst_async: got o=%h s=%0d lk=%b fv=%b err=%b want all 0",
                               {o0, o1, o2, o3}, s, locked, frame_valid, sync_err);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 4'h3, 1'b0);
        n_cmp++;
        if (locked !== 1'b0 || s !== 2'd0) begin n_fail++; $display("FAIL arst_needsync: got lk=%b s=%0d want 0 0", locked, s); end
    endtask

    task automatic test_random();
        bit e, sy, c;
        logic [1:0] exp_s;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            e  = ($urandom_range(0, 3) != 0);
            sy = ($urandom_range(0, 4) == 0) || (i % 9 == 0);
            c  = ($urandom_range(0, 9) == 0);
            drive(e, sy, W'($urandom), c);
            exp_s = 2'(m_q.size());
            n_cmp++;
            if ({o0, o1, o2, o3} !== {m_o[0], m_o[1], m_o[2], m_o[3]} || s !== exp_s ||
                frame_valid !== m_fv || locked !== m_locked || sync_err !== m_err) begin
                n_fail++;
                $display("FAIL rand[%0d]: got o=%h s=%0d fv=%b lk=%b err=%b want o=%h s=%0d fv=%b lk=%b err=%b",
                         i, {o0, o1, o2, o3}, s, frame_valid, locked, sync_err,
                         {m_o[0], m_o[1], m_o[2], m_o[3]}, exp_s, m_fv, m_locked, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_frame();
        test_bubbles();
        test_early_sync();
        test_missing_sync();
        test_err_clr();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side partner of the 4:1 channel multiplexer.
- Accepts a time-division-multiplexed stream: one WIDTH-bit slot per enabled cycle, four slots per frame, slot 0 flagged by `sync`.
- Locks to the frame and routes each slot to its own channel register.
- Presents all four channels atomically once per complete frame. Exports its slot count so the upstream mux select (s1,s0) can be driven or cross-checked.

Parameters:
- WIDTH, 1, data bits per slot/channel (1..32).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- en  input  1  slot strobe; one slot consumed per rising edge with en=1
- sync  input  1  high with en marks current slot as slot 0
- d  input  WIDTH  slot data
- err_clr  input  1  synchronous clear of sync_err
- o0  output  WIDTH  channel 0 (registered)
- o1  output  WIDTH  channel 1 (registered)
- o2  output  WIDTH  channel 2 (registered)
- o3  output  WIDTH  channel 3 (registered)
- s  output  2  next expected slot index (s[1]=s1, s[0]=s0 of upstream mux)
- frame_valid  output  1  one-cycle pulse coincident with new o0..o3
- locked  output  1  high in LOCKED state
- sync_err  output  1  sticky framing-error flag

Behaviour:
- Reset (rst_n=0, asynchronous), all of the following:
  - state=HUNT, cnt=0, s=0
  - o0..o3=0, shadow regs=0
  - frame_valid=0, locked=0, sync_err=0
- Release: state/data registers update on rising edges only.
- en=0: all state, cnt, shadows and outputs hold; frame_valid=0.
- FSM, two states, evaluated only on edges with en=1:
  - HUNT:
    - sync=0: discard d.
    - sync=1: shadow0<=d, cnt<=1, ->LOCKED.
  - LOCKED, normal slot (sync==(cnt==0)):
    - cnt=0,1,2: shadow[cnt]<=d, cnt<=cnt+1.
    - cnt=3: o0<=shadow0, o1<=shadow1, o2<=shadow2, o3<=d on the same edge; cnt<=0 (wrap); frame_valid<=1 for exactly one cycle.
  - LOCKED, early sync (sync=1, cnt!=0):
    - sync_err<=1; partial frame discarded, o* unchanged.
    - Treated as new slot 0: shadow0<=d, cnt<=1; stay LOCKED.
  - LOCKED, missing sync (sync=0, cnt=0):
    - sync_err<=1, d discarded.
    - ->HUNT, cnt<=0; o* unchanged.
- Latency: slot-3 data appears on o3 one edge after it is presented; o0..o2 update on that same edge, never individually.
- s = cnt: 0 in HUNT, otherwise the slot index expected on the next enabled edge.
- locked is a registered decode of state: asserts the cycle after the sync edge, deasserts the cycle after the missing-sync edge.
- sync_err:
  - Set on any framing error.
  - Cleared by err_clr=1 (independent of en).
  - Error and err_clr on the same edge: error wins, sync_err stays 1.
- Reset mid-frame: partial frame lost, o* return to 0; a new sync is required.
- frame_valid never asserts in HUNT or on an error edge.

Test Plan:
- WIDTH=4, reset, then en=1 with (sync,d)=(1,A),(0,B),(0,C),(0,D) -> after 4th edge: o0..o3=A,B,C,D, frame_valid=1 for one cycle; s sequence 0,1,2,3,0; locked=1 from cycle after first edge.
- Same frame with en=0 bubbles inserted between every slot -> identical outputs; frame_valid only after the 4th enabled edge; s holds during bubbles.
- Lock, complete frame 1..4, then sync=1 at slot 2 -> sync_err=1, o* still 1..4, no frame_valid; following three slots 7,8,9 (after the resync slot value 6) -> o*=6,7,8,9.
- Lock, complete a frame, then sync=0 at slot 0 -> sync_err=1, locked=0 next cycle, s=0; data ignored until next sync.
- Assert err_clr alone -> sync_err=0; assert err_clr on same edge as an early-sync error -> sync_err remains 1.
- Pull rst_n low asynchronously mid-frame (cnt=2) -> o*=0, s=0, locked=0, frame_valid=0 immediately, without a clock edge.
